// File: rtl/step_motor_sequencer.sv
// Step/direction pulse sequencer for a stepper motor driver, controlled over
// an Avalon-MM slave. Emits a programmed number of step pulses, tracks a
// signed position and the residual step count, and raises a level interrupt
// on move completion. Optional trapezoidal ramp is compiled in by defining
// STEP_MOTOR_SEQ_RAMP_EN; without it every step uses the constant PERIOD.
module step_motor_sequencer #(
    parameter int PULSE_W = 16
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_ctrl_address,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    output logic        step,
    output logic        forward_back,
    output logic        on_off,
    input  logic        fault,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [31:0] PW         = 32'(PULSE_W);
    localparam logic [31:0] MIN_PERIOD = 32'(2 * PULSE_W);

    state_t             state, state_n;
    logic [31:0]        cnt;
    logic               dir_cfg, irq_en, enable;
    logic [31:0]        steps_cfg, period_cfg;
    logic               done, fault_latched, abort_pend;
    logic signed [31:0] position;
    logic [31:0]        remaining;
    logic [31:0]        cur_period, eff_period, low_len;
    logic               wr_ctrl, start_ok, abort_req, set_done;
    logic               high_end, low_end, start_go, step_adv, busy;
`ifdef STEP_MOTOR_SEQ_RAMP_EN
    logic [31:0]        start_cfg, accel_cfg;
    logic [31:0]        sh_period, sh_start, sh_accel, accel_cnt;
    logic               ramp_on;
`endif

    // Byte-lane merge for the byteenable-qualified configuration registers.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign avs_ctrl_waitrequest = 1'b0;
    assign wr_ctrl    = avs_ctrl_write && (avs_ctrl_address == 3'd0);
    assign abort_req  = wr_ctrl && avs_ctrl_writedata[1];
    assign start_ok   = wr_ctrl && avs_ctrl_writedata[0] && avs_ctrl_writedata[4]
                        && !fault_latched;
    assign busy       = (state != IDLE);
    assign eff_period = (cur_period < MIN_PERIOD) ? MIN_PERIOD : cur_period;
    assign low_len    = eff_period - PW;
    assign high_end   = (state == HIGH) && (cnt == PW - 32'd1);
    assign low_end    = (state == LOW) && (cnt == low_len - 32'd1);
    assign start_go   = (state == IDLE) && (state_n == HIGH);
    assign step_adv   = (state == LOW) && (state_n == HIGH);
    assign on_off     = enable && !fault_latched;
    assign irq        = done && irq_en;

    // Host-writable configuration; the running move works from shadow copies.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            dir_cfg    <= 1'b0;
            irq_en     <= 1'b0;
            enable     <= 1'b0;
            steps_cfg  <= '0;
            period_cfg <= '0;
`ifdef STEP_MOTOR_SEQ_RAMP_EN
            start_cfg  <= '0;
            accel_cfg  <= '0;
`endif
        end else if (avs_ctrl_write) begin
            case (avs_ctrl_address)
                3'd0: begin
                    dir_cfg <= avs_ctrl_writedata[2];
                    irq_en  <= avs_ctrl_writedata[3];
                    enable  <= avs_ctrl_writedata[4];
                end
                3'd1: steps_cfg  <= merge(steps_cfg, avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd2: period_cfg <= merge(period_cfg, avs_ctrl_writedata, avs_ctrl_byteenable);
`ifdef STEP_MOTOR_SEQ_RAMP_EN
                3'd3: start_cfg  <= merge(start_cfg, avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd4: accel_cfg  <= merge(accel_cfg, avs_ctrl_writedata, avs_ctrl_byteenable);
`endif
                default: ;
            endcase
        end
    end

    // Next-state logic; a driver fault overrides everything and parks in IDLE.
    always_comb begin
        state_n  = state;
        set_done = 1'b0;
        if (fault) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    if (steps_cfg == '0) set_done = 1'b1;
                    else                 state_n  = HIGH;
                end
                HIGH: if (high_end) begin
                    if (abort_pend || abort_req) begin
                        state_n  = IDLE;
                        set_done = 1'b1;
                    end else begin
                        state_n  = LOW;
                    end
                end
                LOW: if (abort_req || (low_end && remaining == '0)) begin
                    state_n  = IDLE;
                    set_done = 1'b1;
                end else if (low_end) begin
                    state_n  = HIGH;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, phase counter and a registered step output (glitch-free pin).
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state <= IDLE;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 32'd1;
            step  <= (state_n == HIGH);
        end
    end

    // Move bookkeeping: position/remaining update on every entry to HIGH.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            forward_back <= 1'b0;
            position     <= '0;
            remaining    <= '0;
            abort_pend   <= 1'b0;
        end else begin
            if (start_go) begin
                remaining    <= steps_cfg - 32'd1;
                forward_back <= avs_ctrl_writedata[2];
                position     <= avs_ctrl_writedata[2] ? position + 32'sd1 : position - 32'sd1;
            end else if (step_adv) begin
                remaining    <= remaining - 32'd1;
                position     <= forward_back ? position + 32'sd1 : position - 32'sd1;
            end
            if (state_n == IDLE)
                abort_pend <= 1'b0;
            else if (abort_req && state == HIGH)
                abort_pend <= 1'b1;
        end
    end

    // Sticky status flags: any STATUS write clears, a new event wins.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            done          <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            if (avs_ctrl_write && avs_ctrl_address == 3'd5) begin
                done          <= 1'b0;
                fault_latched <= 1'b0;
            end
            if (start_go) done <= 1'b0;
            if (set_done) done <= 1'b1;
            if (fault)    fault_latched <= 1'b1;
        end
    end

`ifdef STEP_MOTOR_SEQ_RAMP_EN
    assign ramp_on = (sh_start > sh_period);

    // Trapezoidal profile: accelerate until PERIOD, mirror the count on the way down.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            cur_period <= '0;
            sh_period  <= '0;
            sh_start   <= '0;
            sh_accel   <= '0;
            accel_cnt  <= '0;
        end else if (start_go) begin
            cur_period <= (start_cfg > period_cfg) ? start_cfg : period_cfg;
            sh_period  <= period_cfg;
            sh_start   <= start_cfg;
            sh_accel   <= accel_cfg;
            accel_cnt  <= '0;
        end else if (step_adv && ramp_on) begin
            if ({1'b0, remaining} <= {1'b0, accel_cnt} + 33'd1) begin
                if ({1'b0, cur_period} + {1'b0, sh_accel} >= {1'b0, sh_start})
                    cur_period <= sh_start;
                else
                    cur_period <= cur_period + sh_accel;
            end else if (cur_period > sh_period) begin
                accel_cnt <= accel_cnt + 32'd1;
                if ({1'b0, cur_period} > {1'b0, sh_period} + {1'b0, sh_accel})
                    cur_period <= cur_period - sh_accel;
                else
                    cur_period <= sh_period;
            end
        end
    end
`else
    // Constant-rate build: period is captured once per move.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset)
            cur_period <= '0;
        else if (start_go)
            cur_period <= period_cfg;
    end
`endif

    // Registered read mux; data is valid the cycle after the read strobe.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            avs_ctrl_readdata <= '0;
        end else if (avs_ctrl_read) begin
            case (avs_ctrl_address)
                3'd0: avs_ctrl_readdata <= {27'd0, enable, irq_en, dir_cfg, 2'b00};
                3'd1: avs_ctrl_readdata <= steps_cfg;
                3'd2: avs_ctrl_readdata <= period_cfg;
`ifdef STEP_MOTOR_SEQ_RAMP_EN
                3'd3: avs_ctrl_readdata <= start_cfg;
                3'd4: avs_ctrl_readdata <= accel_cfg;
`else
                3'd3: avs_ctrl_readdata <= '0;
                3'd4: avs_ctrl_readdata <= '0;
`endif
                3'd5: avs_ctrl_readdata <= {29'd0, fault_latched, done, busy};
                3'd6: avs_ctrl_readdata <= position;
                3'd7: avs_ctrl_readdata <= remaining;
                default: avs_ctrl_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Self-checking bench for step_motor_sequencer: register table, then
// hand-written move sequences checked through a pulse monitor and a read
// scoreboard (expected read data queued at issue, compared on return).
module tb_step_motor_sequencer;

`ifdef STEP_MOTOR_SEQ_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  ben = '0;
    logic        write = 1'b0, read = 1'b0;
    logic [31:0] rdata;
    logic        wait_req, step, fb, on_off, irq;
    logic        fault = 1'b0;

    always #5 clk = ~clk;

    step_motor_sequencer #(.PULSE_W(16)) dut (
        .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
        .avs_ctrl_address(addr), .avs_ctrl_writedata(wdata),
        .avs_ctrl_byteenable(ben), .avs_ctrl_write(write),
        .avs_ctrl_read(read), .avs_ctrl_readdata(rdata),
        .avs_ctrl_waitrequest(wait_req),
        .step(step), .forward_back(fb), .on_off(on_off),
        .fault(fault), .irq(irq)
    );

    int checks = 0, errors = 0;
    int cyc = 0, rise_cyc = 0;
    int rises[$], widths[$];
    logic step_q = 1'b0, rd_pend = 1'b0;
    logic [31:0] exp_q[$];
    string nm_q[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= read;
    end

    // Pulse monitor: rising-edge cycle stamps and high widths.
    always @(negedge clk) begin
        if (step && !step_q) begin
            rises.push_back(cyc);
            rise_cyc <= cyc;
        end
        if (!step && step_q) widths.push_back(cyc - rise_cyc);
        step_q <= step;
    end

    // Read scoreboard: compare returned data against the queued expectation.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk(nm_q.pop_front(), rdata, exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wrb(input int a, input logic [31:0] d, input logic [3:0] be);
        addr = 3'(a); wdata = d; ben = be; write = 1'b1;
        tick(1);
        write = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wrb(a, d, 4'hF);
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string n);
        addr = 3'(a); read = 1'b1;
        exp_q.push_back(e); nm_q.push_back(n);
        tick(1);
        read = 1'b0;
        tick(1);
    endtask

    task automatic wait_rises(input int target, input string n);
        int k = 0;
        while (rises.size() < target && k < 2000) begin
            tick(1);
            k++;
        end
        chk(n, 32'(rises.size() >= target), 32'd1);
    endtask

    typedef struct {
        int          a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int b, wb;
        int ramp_iv[5];

        vecs[0]  = '{1, 32'h12345678, 4'hF, 32'h12345678, "steps_full"};
        vecs[1]  = '{1, 32'hAABBCCDD, 4'h5, 32'h12BB56DD, "steps_be5"};
        vecs[2]  = '{2, 32'h000000FF, 4'h1, 32'h000000FF, "period_be1"};
        vecs[3]  = '{2, 32'h11223344, 4'hA, 32'h110033FF, "period_beA"};
        vecs[4]  = '{0, 32'h0000001C, 4'hF, 32'h0000001C, "ctrl_rd"};
        vecs[5]  = '{0, 32'h00000008, 4'hF, 32'h00000008, "ctrl_irqen"};
        vecs[6]  = '{3, 32'h00000123, 4'hF, RAMP ? 32'h123 : 32'h0, "start_period"};
        vecs[7]  = '{4, 32'h00000077, 4'hF, RAMP ? 32'h77 : 32'h0, "accel"};
        vecs[8]  = '{6, 32'h00000005, 4'hF, 32'h0, "position_ro"};
        vecs[9]  = '{7, 32'h00000005, 4'hF, 32'h0, "remaining_ro"};
        vecs[10] = '{5, 32'h00000007, 4'hF, 32'h0, "status_idle"};
        ramp_iv = '{200, 150, 100, 150, 200};

        // Reset values
        #12;
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_fb", 32'(fb), 32'd0);
        chk("rst_on_off", 32'(on_off), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", rdata, 32'd0);
        chk("waitrequest", 32'(wait_req), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Register table
        for (int i = 0; i < 11; i++) begin
            wrb(vecs[i].a, vecs[i].d, vecs[i].be);
            rd(vecs[i].a, vecs[i].exp, vecs[i].name);
        end

        // A: 4 forward steps at period 100 with irq; mid-move writes shadowed
        wr(1, 4); wr(2, 100);
        b = rises.size(); wb = widths.size();
        wr(0, 32'h1D);
        tick(20);
        rd(5, 32'h1, "A_busy");
        wr(0, 32'h1D); wr(2, 50);
        tick(400);
        chk("A_pulses", 32'(rises.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) chk("A_width", 32'(widths[wb+i]), 32'd16);
        for (int i = 0; i < 3; i++) chk("A_interval", 32'(rises[b+i+1] - rises[b+i]), 32'd100);
        rd(6, 32'd4, "A_position");
        rd(7, 32'd0, "A_remaining");
        rd(5, 32'h2, "A_done");
        chk("A_fb", 32'(fb), 32'd1);
        chk("A_irq", 32'(irq), 32'd1);
        wr(5, 0);
        chk("A_irq_clr", 32'(irq), 32'd0);

        // B: period 10 clamps to 32; irq gated off by irq_en=0
        wr(1, 2); wr(2, 10);
        b = rises.size(); wb = widths.size();
        wr(0, 32'h15);
        tick(80);
        chk("B_pulses", 32'(rises.size() - b), 32'd2);
        chk("B_width", 32'(widths[wb]), 32'd16);
        chk("B_interval", 32'(rises[b+1] - rises[b]), 32'd32);
        chk("B_irq_gated", 32'(irq), 32'd0);
        rd(5, 32'h2, "B_done");
        rd(6, 32'd6, "B_position");

        // C: abort during the 3rd HIGH of a 10-step move
        wr(5, 0); wr(1, 10); wr(2, 100);
        b = rises.size(); wb = widths.size();
        wr(0, 32'h15);
        wait_rises(b + 3, "C_third_pulse");
        tick(5);
        wr(0, 32'h16);
        tick(60);
        chk("C_pulses", 32'(rises.size() - b), 32'd3);
        chk("C_width3", 32'(widths[wb+2]), 32'd16);
        rd(7, 32'd7, "C_remaining");
        rd(5, 32'h2, "C_done");
        rd(6, 32'd9, "C_position");

        // D: fault during LOW, start refused until STATUS written
        wr(5, 0); wr(1, 5);
        b = rises.size();
        wr(0, 32'h15);
        wait_rises(b + 1, "D_first_pulse");
        tick(30);
        fault = 1'b1;
        tick(1);
        fault = 1'b0;
        chk("D_step_low", 32'(step), 32'd0);
        chk("D_on_off", 32'(on_off), 32'd0);
        rd(5, 32'h4, "D_fault_latched");
        wr(0, 32'h15);
        tick(150);
        chk("D_start_refused", 32'(rises.size() - b), 32'd1);
        rd(5, 32'h4, "D_still_latched");
        wr(5, 0);
        chk("D_on_off_back", 32'(on_off), 32'd1);
        wr(0, 32'h15);
        tick(3);
        rd(5, 32'h1, "D_restart_busy");
        wr(0, 32'h16);
        tick(120);
        rd(5, 32'h2, "D_abort_done");

        // E: STEPS=0 start completes at once with no pulse
        wr(5, 0); wr(1, 0);
        b = rises.size();
        wr(0, 32'h1D);
        chk("E_irq_next_cycle", 32'(irq), 32'd1);
        tick(50);
        chk("E_no_pulse", 32'(rises.size() - b), 32'd0);
        rd(5, 32'h2, "E_done");

        // R: reset mid-pulse drops step immediately and clears state
        wr(5, 0); wr(1, 3); wr(2, 100);
        b = rises.size();
        wr(0, 32'h15);
        wait_rises(b + 1, "R_pulse_started");
        tick(3);
        #3 rst = 1'b1;
        #1;
        chk("R_step_async", 32'(step), 32'd0);
        chk("R_on_off", 32'(on_off), 32'd0);
        chk("R_fb", 32'(fb), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("R_readdata", rdata, 32'd0);
        rd(6, 32'd0, "R_position");
        rd(7, 32'd0, "R_remaining");
        rd(1, 32'd0, "R_steps");

        // Reverse 3 steps from zero wraps position
        wr(0, 32'h10); wr(1, 3); wr(2, 40);
        wr(0, 32'h11);
        tick(130);
        rd(6, 32'hFFFFFFFD, "rev_position");
        chk("rev_fb", 32'(fb), 32'd0);

`ifdef STEP_MOTOR_SEQ_RAMP_EN
        // Trapezoidal ramp 200 -> 100 -> 200
        wr(3, 200); wr(4, 50); wr(2, 100); wr(1, 6);
        b = rises.size();
        wr(0, 32'h15);
        tick(1050);
        chk("ramp_pulses", 32'(rises.size() - b), 32'd6);
        for (int i = 0; i < 5; i++)
            chk("ramp_interval", 32'(rises[b+i+1] - rises[b+i]), 32'(ramp_iv[i]));
`else
        // Ramp registers absent in this build
        wr(3, 200); wr(4, 50);
        rd(3, 32'd0, "no_ramp_start");
        rd(4, 32'd0, "no_ramp_accel");
        chk("ramp_tbl", 32'(ramp_iv[0]), 32'd200);
`endif

        tick(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
